// File: rtl/loop_replay_issuer.sv
// Replays a captured loop from the uop cache into decode with reconstructed PCs; LOOP_ITER_LIMIT_EN adds a max_iter cap.
// Latency: first out_valid 2 cycles after start is sampled, then 1 entry/cycle including across the wrap.
// Backpressure: a 2-entry output FIFO absorbs in-flight reads; reads only issue while FIFO + in-flight has a free slot.
module loop_replay_issuer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   loop_len_i,
    input  logic [31:0]       base_pc_i,
`ifdef LOOP_ITER_LIMIT_EN
    input  logic [15:0]       max_iter_i,
`endif
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_instruction_o,
    output logic [31:0]       out_pc_o,
    input  logic              mispredict_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       iter_count_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [31:0]       base_pc_q, base_pc_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_idx_q, inflight_idx_d;
    logic [DATA_W-1:0] fifo_dat_q [2];
    logic [ADDR_W-1:0] fifo_idx_q [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [15:0]       iter_q, iter_d;
    logic              done_q, done_d;
`ifdef LOOP_ITER_LIMIT_EN
    logic [15:0]       max_iter_q, max_iter_d;
    logic [15:0]       rd_iter_q, rd_iter_d;
`endif

    logic              pop;
    logic              push;
    logic              kill;
    logic              start_ok;
    logic              rd_last;
    logic              head_last;
    logic [2:0]        occ_after_pop;
    logic [ADDR_W:0]   last_idx;

    assign last_idx      = len_q - ONE_L;
    assign out_valid_o   = (count_q != 2'd0);
    assign pop           = out_valid_o & out_ready_i;
    assign push          = inflight_q;
    assign kill          = mispredict_i & (state_q != S_IDLE);
    assign start_ok      = start_i & (state_q == S_IDLE) & (loop_len_i != '0);
    // Counting the current pop lets a read issue in the same cycle a slot frees up.
    assign occ_after_pop = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en_o       = (state_q == S_STREAM) & ~kill & (occ_after_pop < 3'd2);
    assign rd_addr_o     = rd_idx_q;
    assign rd_last       = ({1'b0, rd_idx_q} == last_idx);
    assign head_last     = ({1'b0, fifo_idx_q[head_q]} == last_idx);

    assign out_instruction_o = out_valid_o ? fifo_dat_q[head_q] : '0;
    assign out_pc_o          = out_valid_o ? (base_pc_q + 32'({fifo_idx_q[head_q], 2'b00})) : 32'd0;
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = done_q;
    assign iter_count_o      = iter_q;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        base_pc_d      = base_pc_q;
        rd_idx_d       = rd_idx_q;
        inflight_d     = rd_en_o;
        inflight_idx_d = rd_en_o ? rd_idx_q : inflight_idx_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q + {1'b0, push} - {1'b0, pop};
        iter_d         = iter_q;
        done_d         = 1'b0;
`ifdef LOOP_ITER_LIMIT_EN
        max_iter_d     = max_iter_q;
        rd_iter_d      = rd_iter_q;
`endif

        if (pop) begin
            head_d = ~head_q;
            if (head_last && (iter_q != 16'hFFFF)) begin
                iter_d = iter_q + 16'd1;
            end
        end
        if (push) begin
            tail_d = ~tail_q;
        end

        if (rd_en_o) begin
            rd_idx_d = rd_last ? '0 : rd_idx_q + ADDR_W'(1);
`ifdef LOOP_ITER_LIMIT_EN
            if (rd_last) begin
                if (rd_iter_q != 16'hFFFF) begin
                    rd_iter_d = rd_iter_q + 16'd1;
                end
                if ((max_iter_q != 16'd0) && (({1'b0, rd_iter_q} + 17'd1) == {1'b0, max_iter_q})) begin
                    state_d = S_DRAIN;
                end
            end
`endif
        end

        // Drain ends when the final buffered entry leaves and nothing is still coming back from the cache.
        if ((state_q == S_DRAIN) && pop && (count_q == 2'd1) && !inflight_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end

        if (start_ok) begin
            state_d   = S_STREAM;
            base_pc_d = base_pc_i;
            len_d     = (loop_len_i > DEPTH_L) ? DEPTH_L : loop_len_i;
            rd_idx_d  = '0;
            iter_d    = '0;
`ifdef LOOP_ITER_LIMIT_EN
            rd_iter_d  = '0;
            max_iter_d = max_iter_i;
`endif
        end

        // A handshake in the abort cycle still counts toward iter_count above.
        if (kill) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            inflight_d = 1'b0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
            count_d    = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            base_pc_q      <= '0;
            rd_idx_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            count_q        <= 2'd0;
            iter_q         <= '0;
            done_q         <= 1'b0;
`ifdef LOOP_ITER_LIMIT_EN
            max_iter_q     <= '0;
            rd_iter_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            base_pc_q      <= base_pc_d;
            rd_idx_q       <= rd_idx_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            iter_q         <= iter_d;
            done_q         <= done_d;
`ifdef LOOP_ITER_LIMIT_EN
            max_iter_q     <= max_iter_d;
            rd_iter_q      <= rd_iter_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fifo_dat_q[0] <= '0;
            fifo_dat_q[1] <= '0;
            fifo_idx_q[0] <= '0;
            fifo_idx_q[1] <= '0;
        end else if (push && !kill) begin
            fifo_dat_q[tail_q] <= rd_data_i;
            fifo_idx_q[tail_q] <= inflight_idx_q;
        end
    end

endmodule
